mod_n_serial_detector: RTL and testbench
========================================

# mod_n_serial_detector

Parametrised successor to the team's multiple-of-three detector FSM. It consumes a serial bitstream one bit per qualified clock. It reports whether the number read so far is divisible by a configurable DIVISOR, together with the running remainder. Both MSB-first and LSB-first bit order are supported, along with a per-number clear and a saturating bit counter. It sits between a serial source and downstream checking logic, and replaces the fixed mod-3 detector wherever other divisors or bit orders are needed.

## Interface
- DIVISOR, 3, modulus; legal range 2..255
- MAX_BITS, 32, bit-count saturation limit; legal range ≥1
- LSB_FIRST, 0, 0 = bits arrive MSB-first, 1 = bits arrive LSB-first
- Derived widths:
  - RW = max(1, $clog2(DIVISOR))
  - CW = $clog2(MAX_BITS+1)
- Ports:
  - clk  input  1  clock; all state updates on the rising edge
  - reset  input  1  synchronous, active-high reset; highest priority
  - in  input  1  serial data bit
  - in_valid  input  1  qualifies in; a bit is consumed only on an edge where in_valid=1
  - clear  input  1  starts a new number (synchronous, single-cycle pulse)
  - out  output  1  1 when the number read so far is ≡ 0 mod DIVISOR
  - remainder  output  RW  number read so far mod DIVISOR
  - bit_count  output  CW  bits consumed since reset/clear, saturating at MAX_BITS
  - len_sat  output  1  1 when bit_count == MAX_BITS

## Operation
- Internal state:
  - r: remainder, RW bits
  - w: LSB mode only; weight 2^k mod DIVISOR, RW bits
  - cnt: bit count, CW bits
- The empty number is 0, so r=0, w=1, cnt=0.
- MSB-first update on a consumed bit b: r' = (2r + b) mod DIVISOR.
- LSB-first update on a consumed bit b:
  - r' = (r + b·w) mod DIVISOR
  - w' = (2w) mod DIVISOR
- Arithmetic rules:
  - Intermediate sums are computed at RW+1 bits and reduced by at most one conditional subtract. 2r+b < 2·DIVISOR and r+w < 2·DIVISOR, so no divider is used.
  - r and w never hold values ≥ DIVISOR.
- Outputs:
  - out = (r == 0)
  - remainder = r
  - Both are registered state; no combinational path from in to out.
- Bit counter:
  - cnt increments per consumed bit and holds at MAX_BITS.
  - Bits beyond MAX_BITS are still folded into r (and w). Divisibility stays exact for arbitrarily long streams; only the count saturates.
- Priority on each rising edge:
  1. reset: r=0, w=1, cnt=0.
  2. clear & in_valid: restart, then consume in as the first bit of the new number:
     - r = in mod DIVISOR
     - w = 2 mod DIVISOR (LSB mode)
     - cnt = 1
  3. clear alone: r=0, w=1, cnt=0.
  4. in_valid alone: normal update.
  5. Otherwise: hold all state.
- Conceptual states for the DIVISOR=3 MSB case are S0/S1/S2 = remainder 0/1/2. The general block is the DIVISOR-state remainder FSM, with a second DIVISOR-state weight FSM in LSB mode.

## Timing
- Reset values: out=1, remainder=0, bit_count=0, len_sat=0.
- Latency:
  - A bit sampled at edge k is reflected in out, remainder and bit_count immediately after edge k, i.e. readable in cycle k+1.
  - Throughput is one bit per cycle.
- in_valid may deassert for any number of cycles; outputs hold and the next valid bit continues the same number.
- reset asserted mid-stream discards the partial number on that edge; any bit presented with it is ignored.
- clear is level-sampled. Holding it high for n cycles with in_valid=1 restarts each cycle, so only the last bit survives (cnt=1).
- len_sat rises on the edge where cnt reaches MAX_BITS and falls only on clear or reset.

## Test plan
- DIVISOR=3, MSB: reset, then bits 1,0,0,1,0,1,0,1,0,1 on consecutive cycles (values 1,2,4,9,18,37,74,149,298,597).
  - Required remainder: 1,2,1,0,0,1,2,2,1,0
  - Required out: 0,0,0,1,1,0,0,0,0,1
  - Required final bit_count: 10
- DIVISOR=5, LSB_FIRST=1: bits 1,0,0,1,1 (value 25).
  - Required remainder: 1,1,1,4,0
  - Required final out: 1
- DIVISOR=7, MSB: bits 1,1,1 (7) with in_valid low for 3 cycles between bits 2 and 3.
  - Outputs hold at remainder=3 during the gap.
  - Final remainder=0, out=1, bit_count=3.
- DIVISOR=3: after value 5 (bits 1,0,1; remainder 2), assert clear together with in_valid and in=1.
  - Required next state: remainder=1, out=0, bit_count=1.
  - Then clear alone gives out=1, remainder=0, bit_count=0.
- MAX_BITS=4, DIVISOR=3, MSB: 6 bits 1,1,0,0,0,0 (value 48).
  - bit_count reads 1,2,3,4,4,4.
  - len_sat rises after the 4th bit.
  - Final out=1, remainder=0.
- Reset mid-stream: DIVISOR=3, bits 1,0 (remainder 2), then reset held for 1 cycle with in_valid=1 and in=1.
  - Required after reset: out=1, remainder=0, bit_count=0, len_sat=0.
  - Next bit 1 gives remainder=1.

Source files
------------

// File: rtl/mod_n_serial_detector.sv
`default_nettype none
// ============================================================================
// mod_n_serial_detector : serial-number remainder / divisibility by DIVISOR
// Revision 1.0
// ============================================================================
module mod_n_serial_detector #(
  parameter int DIVISOR   = 3,
  parameter int MAX_BITS  = 32,
  parameter int LSB_FIRST = 0,
  localparam int RW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1,
  localparam int CW = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in,
  input  logic          in_valid,
  input  logic          clear,
  output logic          out,
  output logic [RW-1:0] remainder,
  output logic [CW-1:0] bit_count,
  output logic          len_sat
);

  localparam logic [RW:0]   DIV_EXT = (RW + 1)'(DIVISOR);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);

  // Operands are always < 2*DIVISOR, so one conditional subtract suffices.
  function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] s);
    return (s >= DIV_EXT) ? RW'(s - DIV_EXT) : RW'(s);
  endfunction

  logic [RW-1:0] r_q;
  logic [RW-1:0] base_r;
  logic [RW-1:0] r_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] base_cnt;
  logic [CW-1:0] cnt_nxt;

  // A clear coinciding with a valid bit updates from the empty number.
  always_comb begin
    base_r   = clear ? '0 : r_q;
    base_cnt = clear ? '0 : cnt_q;
    cnt_nxt  = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CW'(1);
  end

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      logic [RW-1:0] w_q;
      logic [RW-1:0] base_w;
      logic [RW-1:0] w_nxt;

      always_comb begin
        base_w = clear ? RW'(1) : w_q;
        r_nxt  = mod_reduce({1'b0, base_r} + (in ? {1'b0, base_w} : '0));
        w_nxt  = mod_reduce({base_w, 1'b0});
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          w_q <= RW'(1);
        end else if (in_valid) begin
          w_q <= w_nxt;
        end else if (clear) begin
          w_q <= RW'(1);
        end
      end
    end else begin : g_msb
      always_comb begin
        r_nxt = mod_reduce({base_r, in});
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      cnt_q <= '0;
    end else if (in_valid) begin
      r_q   <= r_nxt;
      cnt_q <= cnt_nxt;
    end else if (clear) begin
      r_q   <= '0;
      cnt_q <= '0;
    end
  end

  assign out       = (r_q == '0);
  assign remainder = r_q;
  assign bit_count = cnt_q;
  assign len_sat   = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_mod_n_serial_detector.sv
`default_nettype none
// ============================================================================
// tb_mod_n_serial_detector : scoreboard bench over several detector configs
// Revision 1.0
// ============================================================================
module tb_mod_n_serial_detector;

  localparam int NI = 6;
  localparam int DIVS [NI] = '{3, 5, 7, 3, 2, 255};
  localparam int LSBS [NI] = '{0, 1, 0, 0, 1, 1};
  localparam int MAXS [NI] = '{32, 32, 32, 4, 1, 300};

  typedef struct packed {
    logic        o;
    logic [7:0]  rem;
    logic [15:0] cnt;
    logic        sat;
  } exp_t;

  logic clk;
  logic reset;
  logic in_b;
  logic in_valid;
  logic clear;

  logic        dout [NI];
  logic [7:0]  drem [NI];
  logic [15:0] dcnt [NI];
  logic        dsat [NI];

  exp_t sbq [$];
  bit   bits_q [$];
  int   checks;
  int   failures;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RW = (DIVS[g] > 2) ? $clog2(DIVS[g]) : 1;
      localparam int CW = $clog2(MAXS[g] + 1);
      logic          o;
      logic [RW-1:0] rem;
      logic [CW-1:0] cnt;
      logic          sat;

      mod_n_serial_detector #(
        .DIVISOR  (DIVS[g]),
        .MAX_BITS (MAXS[g]),
        .LSB_FIRST(LSBS[g])
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_b),
        .in_valid (in_valid),
        .clear    (clear),
        .out      (o),
        .remainder(rem),
        .bit_count(cnt),
        .len_sat  (sat)
      );

      assign dout[g] = o;
      assign drem[g] = 8'(rem);
      assign dcnt[g] = 16'(cnt);
      assign dsat[g] = sat;
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Value of the stored number mod d; LSB-first streams are read back-to-front.
  function automatic int number_mod(input bit q[$], input int d, input bit lsb_first);
    int r = 0;
    int n = q.size();
    for (int i = 0; i < n; i++) begin
      int b = lsb_first ? int'(q[n - 1 - i]) : int'(q[i]);
      r = (2 * r + b) % d;
    end
    return r;
  endfunction

  task automatic push_expected();
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      int   r;
      int   c;
      r     = number_mod(bits_q, DIVS[i], LSBS[i] != 0);
      c     = (bits_q.size() < MAXS[i]) ? bits_q.size() : MAXS[i];
      e.o   = (r == 0);
      e.rem = 8'(r);
      e.cnt = 16'(c);
      e.sat = (c == MAXS[i]);
      sbq.push_back(e);
    end
  endtask

  task automatic step(input logic rs, input logic cl, input logic v, input logic b);
    reset    = rs;
    clear    = cl;
    in_valid = v;
    in_b     = b;
    @(posedge clk);
    if (rs) begin
      bits_q.delete();
    end else if (cl && v) begin
      bits_q.delete();
      bits_q.push_back(b);
    end else if (cl) begin
      bits_q.delete();
    end else if (v) begin
      bits_q.push_back(b);
    end
    push_expected();
    #1;
  endtask

  task automatic send_bits(input logic [15:0] pattern, input int n);
    logic [15:0] p;
    p = pattern;
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, p[i]);
  endtask

  task automatic chk(input string name, input int inst, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() >= NI) begin
      for (int i = 0; i < NI; i++) begin
        exp_t e;
        e = sbq.pop_front();
        chk("out", i, 16'(dout[i]), 16'(e.o));
        chk("remainder", i, 16'(drem[i]), 16'(e.rem));
        chk("bit_count", i, dcnt[i], e.cnt);
        chk("len_sat", i, 16'(dsat[i]), 16'(e.sat));
      end
    end
  end

  initial begin
    int wait_cycles;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_b     = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // 597 = 1001010101 MSB-first
    send_bits(16'b1001010101, 10);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    // 25 LSB-first: 1,0,0,1,1
    send_bits(16'b10011, 5);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b11, 2);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(16'b1, 1);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b110000, 6);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(16'b10, 2);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    send_bits(16'b1, 1);

    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    wait_cycles = 0;
    while (sbq.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
